// File: rtl/shift_register_pkg.sv
// Shared constants for the bidirectional shift register.
// Direction encodings and the legal WIDTH bounds.
package shift_register_pkg;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/shift_register.sv
// Bidirectional SISO/SIPO shift register with synchronous parallel load.
// Define SHIFT_REGISTER_ROTATE_EN to add the rot input (rotate instead of shift).
module shift_register
    import shift_register_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             si,
`ifdef SHIFT_REGISTER_ROTATE_EN
    input  logic             rot,
`endif
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             so
);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
            $error("shift_register: WIDTH %0d outside %0d..%0d",
                   WIDTH, WIDTH_MIN, WIDTH_MAX);
        end
    endgenerate

    function automatic logic [WIDTH-1:0] shift_next(
        input logic [WIDTH-1:0] value,
        input logic             towards,
        input logic             fill
    );
        if (towards == DIR_LEFT)
            return {value[WIDTH-2:0], fill};
        else
            return {fill, value[WIDTH-1:1]};
    endfunction

    // A rotate feeds back exactly the bit a shift would discard, which is so.
    logic fill;

`ifdef SHIFT_REGISTER_ROTATE_EN
    assign fill = rot ? so : si;
`else
    assign fill = si;
`endif

    assign so = (dir == DIR_LEFT) ? q[WIDTH-1] : q[0];

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (load)
            q <= d;
        else if (en)
            q <= shift_next(q, dir, fill);
    end

endmodule

// File: tb/tb_shift_register.sv
// Randomised and directed bench for shift_register against an arithmetic model.
// Honours SHIFT_REGISTER_ROTATE_EN to exercise rotate mode as well.
module tb_shift_register;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, en, dir, si, load;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         so;
    logic         rot_m;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] m;

    always #5 clk = ~clk;

    shift_register #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .dir  (dir),
        .si   (si),
`ifdef SHIFT_REGISTER_ROTATE_EN
        .rot  (rot_m),
`endif
        .load (load),
        .d    (d),
        .q    (q),
        .so   (so)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic model_so();
        return dir ? m[0] : m[W-1];
    endfunction

    // Reference: rules applied with plain arithmetic on an integer value.
    task automatic model_edge();
        logic         b;
        logic [W-1:0] top;
        if (rst)
            m = '0;
        else if (load)
            m = d;
        else if (en) begin
            b = rot_m ? model_so() : si;
            if (!dir) begin
                m = (m << 1) | W'(b);
            end else begin
                top = W'(b) << (W - 1);
                m = (m >> 1) | top;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("q", 64'(q), 64'(m));
        check("so", 64'(so), 64'(model_so()));
    endtask

    logic [7:0] left_bits;
    logic [7:0] right_so;

    initial begin
        m     = '0;
        rst   = 1'b1;
        en    = 1'b1;
        si    = 1'b1;
        load  = 1'b0;
        dir   = 1'b0;
        d     = '0;
        rot_m = 1'b0;

        tick();
        tick();
        check("rst_q", 64'(q), 64'h00);
        check("rst_so", 64'(so), 64'h0);
        rst = 1'b0;
        en  = 1'b0;
        tick();
        check("post_rst_hold", 64'(q), 64'h00);

        left_bits = 8'b10110010;
        dir = 1'b0;
        en  = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            si = left_bits[i];
            tick();
        end
        check("left_final", 64'(q), 64'hB2);

        right_so = 8'b10110010;
        dir = 1'b1;
        si  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("right_so_seq", 64'(so), 64'(right_so[i]));
            tick();
        end
        check("right_zero", 64'(q), 64'h00);

        load = 1'b1;
        d    = 8'hB2;
        tick();
        load = 1'b0;
        si   = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("right_ones", 64'(q), 64'hFF);

        load = 1'b1;
        d    = 8'hA5;
        tick();
        load = 1'b0;
        en   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            si  = ~si;
            dir = ~dir;
            tick();
        end
        check("hold", 64'(q), 64'hA5);

        load = 1'b1;
        d    = 8'h3C;
        en   = 1'b1;
        si   = 1'b1;
        tick();
        check("load_prio", 64'(q), 64'h3C);

        rst = 1'b1;
        tick();
        check("rst_prio", 64'(q), 64'h00);
        rst = 1'b0;

        d = 8'h81;
        tick();
        load = 1'b0;
        dir  = 1'b0;
        si   = 1'b0;
        #1;
        check("dirchg_so_l", 64'(so), 64'h1);
        tick();
        check("dirchg_l", 64'(q), 64'h02);
        dir = 1'b1;
        si  = 1'b1;
        #1;
        check("dirchg_so_r", 64'(so), 64'h0);
        tick();
        check("dirchg_r", 64'(q), 64'h81);

`ifdef SHIFT_REGISTER_ROTATE_EN
        si    = 1'b0;
        rot_m = 1'b1;
        load  = 1'b1;
        d     = 8'h81;
        tick();
        load = 1'b0;
        dir  = 1'b0;
        tick();
        check("rot_l", 64'(q), 64'h03);
        load = 1'b1;
        tick();
        load = 1'b0;
        dir  = 1'b1;
        tick();
        check("rot_r", 64'(q), 64'hC0);
        rot_m = 1'b0;
`endif

        for (int i = 0; i < 2000; i++) begin
            rst  = ($urandom_range(0, 31) == 0);
            load = ($urandom_range(0, 7) == 0);
            en   = $urandom_range(0, 3) != 0;
            dir  = 1'($urandom);
            si   = 1'($urandom);
            d    = W'($urandom);
`ifdef SHIFT_REGISTER_ROTATE_EN
            rot_m = 1'($urandom);
`endif
            #1;
            check("rand_so_comb", 64'(so), 64'(model_so()));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_register.md
Name: shift_register

Overview:
- Parameterised serial-in/serial-out, parallel-out bidirectional shift register with synchronous parallel load.
- Used as a generic serialiser/deserialiser building block, e.g. between serial links and bus-wide datapaths.
- One clock domain, fully synchronous, no internal state other than the data register.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..64. Elaboration error outside this range.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- en  input  1  shift enable; shift occurs on a rising edge when high
- dir  input  1  shift direction: 0 = left (toward MSB), 1 = right (toward LSB)
- si  input  1  serial input bit
- load  input  1  parallel load strobe
- d  input  WIDTH  parallel load data
- q  output  WIDTH  register contents, registered
- so  output  1  serial output, the bit that the next shift in the current direction discards

Behaviour:
- Reset: q = 0 on the first rising edge with rst=1. rst overrides load and en. Mid-operation reset discards contents with no partial shift.
- Priority on each rising edge: rst > load > en > hold.
- load=1: q <= d. en, dir and si are ignored that cycle.
- en=1, dir=0 (left): q <= {q[WIDTH-2:0], si}. Bit q[WIDTH-1] is discarded.
- en=1, dir=1 (right): q <= {si, q[WIDTH-1:1]}. Bit q[0] is discarded.
- en=0, load=0: q holds. Changes on si and dir have no effect on q.
- so is combinational from q and dir only: dir=0 gives q[WIDTH-1]; dir=1 gives q[0]. It is 0 after reset.
- Shift latency is 1 cycle. A bit entering at si appears at the opposite end's so after WIDTH enabled shifts in a constant direction.
- Changing dir between cycles is legal and has no penalty; each edge uses the dir value sampled at that edge.
- X on si during a shift propagates into q. No X-masking.

Optional Feature:
- Macro: SHIFT_REGISTER_ROTATE_EN.
- Defined:
  - Adds input port rot (1 bit).
  - When en=1 and rot=1, the shift becomes a rotate: left gives q <= {q[WIDTH-2:0], q[WIDTH-1]}; right gives q <= {q[0], q[WIDTH-1:1]}.
  - si is ignored during a rotate.
  - so behaviour is unchanged.
  - rot has no effect when en=0, load=1, or rst=1.
- Not defined: no rot port; only plain shift behaviour exists.

Decomposition:
- Package shift_register_pkg holds:
  - DIR_LEFT = 1'b0 and DIR_RIGHT = 1'b1 constants.
  - WIDTH_MIN = 2 and WIDTH_MAX = 64 bounds used by the elaboration check.
- No sub-module. Implement as a single always_ff for the register plus a continuous assignment for so; the next-state mux may be a local function.

Test Plan:
- Reset: WIDTH=8, rst=1 for 2 cycles with en=1, si=1, load=0 -> q=8'h00, so=0. Release rst, en=0 -> q stays 8'h00.
- Left shift: dir=0, en=1, si sequence 1,0,1,1,0,0,1,0 over 8 edges -> q=8'b10110010. so on each cycle equals the previous q[7].
- Right shift: from q=8'b10110010, dir=1, en=1, si=0 for 8 edges -> so emits 0,1,0,0,1,1,0,1, q ends 8'h00. With si=1 throughout instead, q ends 8'hFF.
- Hold and priority:
  - q=8'hA5, en=0, si toggling for 4 cycles -> q stays 8'hA5.
  - load=1, d=8'h3C, en=1, si=1 -> q=8'h3C next cycle.
  - rst=1 with load=1 -> q=8'h00.
- Direction change: load 8'h81, dir=0 shift si=0 -> 8'h02 (so was 1). Then dir=1 shift si=1 -> 8'h81 (so before edge 0).
- Rotate, macro defined: q=8'h81, dir=0, rot=1, en=1 -> 8'h03. dir=1 from 8'h81 -> 8'hC0. si=0 throughout confirms si is ignored.
